zbt_sram_arbiter: RTL

- Shares one ZBT SRAM bank between three requesters: display read (port 0), camera write (port 1) and processing read/write (port 2).
- Issues at most one RAM access per clk and tracks the fixed ZBT pipeline so write data and read returns line up with the issuing requester.
- Sits on the deskewed fpga clock domain and is gated by the clock generator's lock indication.

---
 rtl/zbt_sram_arbiter_pkg.sv | 29 ++
 rtl/zbt_arb_pick.sv | 33 +++
 rtl/zbt_sram_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/zbt_sram_arbiter_pkg.sv
// Shared definitions for the ZBT SRAM arbiter: port indices, default
// geometry/latency and the pipeline entry that tracks each issued access.
package zbt_sram_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned PORT_DISP = 0;
  localparam int unsigned PORT_CAM  = 1;
  localparam int unsigned PORT_PROC = 2;

  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 36;
  localparam int unsigned RD_LAT_DEF = 4;
  localparam int unsigned WR_LAT_DEF = 2;

  localparam int unsigned STAT_W = 16;

  // One issued access travelling down the pipeline.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [1:0] port;
  } pipe_entry_t;

  // One-hot decode of a port id.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] port);
    return NUM_PORTS'(NUM_PORTS'(1) << port);
  endfunction

endpackage

// File: rtl/zbt_arb_pick.sv
// Combinational grant selection: port 0 has strict priority, ports 1 and 2
// share the remainder round-robin.
// Ports:
//   req     per-port request
//   enable  grants allowed (clock locked and out of reset)
//   rr_ptr  0: port 1 wins a 1-vs-2 tie, 1: port 2 wins
//   gnt     one-hot grant (zero when disabled or idle)
module zbt_arb_pick
  import zbt_sram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  input  logic                 rr_ptr,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req[PORT_DISP]) begin
        gnt[PORT_DISP] = 1'b1;
      end else if (req[PORT_CAM] && req[PORT_PROC]) begin
        if (rr_ptr) gnt[PORT_PROC] = 1'b1;
        else        gnt[PORT_CAM]  = 1'b1;
      end else if (req[PORT_CAM]) begin
        gnt[PORT_CAM] = 1'b1;
      end else if (req[PORT_PROC]) begin
        gnt[PORT_PROC] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zbt_sram_arbiter.sv
// Three-port arbiter in front of one pipelined (ZBT) SRAM bank.
// Port 0 = display read, port 1 = camera write, port 2 = processing r/w.
// One access is issued per clock; write data and read returns are aligned
// to the fixed SRAM pipeline and tagged with the issuing port.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   clk_locked             grants only while the clock generator is locked
//   req/we/addr/wdata      per-port request bundle (port i at slice i)
//   gnt                    one-hot acceptance, combinational
//   rdata/rvalid           read return and owning port (one-hot)
//   ram_*                  registered SRAM pins; ram_data_in from the bus
//   busy                   any access still in flight
// Optional: define ZBT_ARB_STATS_EN to add stat_grants / stat_wait_max.
module zbt_sram_arbiter
  import zbt_sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned WR_LAT = WR_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clk_locked,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we_b,
  output logic                          ram_cen_b,
  output logic [DATA_W-1:0]             ram_data_out,
  output logic                          ram_data_oe,
  input  logic [DATA_W-1:0]             ram_data_in,
  output logic                          busy
`ifdef ZBT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*STAT_W-1:0]   stat_grants,
  output logic [STAT_W-1:0]             stat_wait_max
`endif
);

  // The rvalid register is the final stage of the read tracker.
  localparam int unsigned RP_DEPTH = RD_LAT - 1;

  logic [NUM_PORTS-1:0] gnt_pick;
  logic                 rr_ptr_q;
  logic                 acc;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_we;
  logic [DATA_W-1:0]    sel_wdata;
  logic [1:0]           sel_port;
  logic                 busy_d;

  pipe_entry_t          rp_q [RP_DEPTH];
  logic [DATA_W-1:0]    wd_q [WR_LAT];
  logic                 wv_q [WR_LAT];

  // Grant logic; reset forces gnt low immediately.
  zbt_arb_pick u_pick (
    .req    (req),
    .enable (clk_locked & reset_n),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt_pick)
  );

  assign gnt = gnt_pick;

  // Mux the accepted port's request bundle.
  always_comb begin
    acc       = |gnt_pick;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_port  = 2'd0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_pick[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_we    = we[i];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_port  = 2'(i);
      end
    end
  end

  // Round-robin pointer between ports 1 and 2; moves away from the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else if (gnt_pick[PORT_CAM]) begin
      rr_ptr_q <= 1'b1;
    end else if (gnt_pick[PORT_PROC]) begin
      rr_ptr_q <= 1'b0;
    end
  end

  // Issue stage: address/control onto the SRAM pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we_b  <= 1'b1;
      ram_cen_b <= 1'b1;
    end else if (acc) begin
      ram_addr  <= sel_addr;
      ram_we_b  <= ~sel_we;
      ram_cen_b <= 1'b0;
    end else begin
      ram_we_b  <= 1'b1;
      ram_cen_b <= 1'b1;
    end
  end

  // Write data delay: stage 0 is visible with the address, the output
  // register lands WR_LAT cycles after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WR_LAT; i++) begin
        wd_q[i] <= '0;
        wv_q[i] <= 1'b0;
      end
      ram_data_out <= '0;
      ram_data_oe  <= 1'b0;
    end else begin
      wd_q[0] <= sel_wdata;
      wv_q[0] <= acc & sel_we;
      for (int unsigned i = 1; i < WR_LAT; i++) begin
        wd_q[i] <= wd_q[i-1];
        wv_q[i] <= wv_q[i-1];
      end
      ram_data_out <= wd_q[WR_LAT-1];
      ram_data_oe  <= wv_q[WR_LAT-1];
    end
  end

  // Access tracker {valid, we, port}; reads capture the SRAM bus on the
  // edge that moves them into the rvalid stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RP_DEPTH; i++) begin
        rp_q[i] <= '0;
      end
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rp_q[0].valid <= acc;
      rp_q[0].we    <= sel_we;
      rp_q[0].port  <= sel_port;
      for (int unsigned i = 1; i < RP_DEPTH; i++) begin
        rp_q[i] <= rp_q[i-1];
      end
      if (rp_q[RP_DEPTH-1].valid && !rp_q[RP_DEPTH-1].we) begin
        rvalid <= port_onehot(rp_q[RP_DEPTH-1].port);
        rdata  <= ram_data_in;
      end else begin
        rvalid <= '0;
      end
    end
  end

  // busy mirrors the valid bits that will be held after this edge.
  always_comb begin
    busy_d = acc;
    for (int unsigned i = 0; i < RP_DEPTH; i++) begin
      busy_d = busy_d | rp_q[i].valid;
    end
    for (int unsigned i = 0; i < WR_LAT; i++) begin
      busy_d = busy_d | wv_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= busy_d;
    end
  end

`ifdef ZBT_ARB_STATS_EN
  logic [STAT_W-1:0] wait_q [NUM_PORTS];
  logic [STAT_W-1:0] wait_d [NUM_PORTS];
  logic [STAT_W-1:0] wait_max_d;

  // Per-port wait run lengths and the running maximum, saturating.
  always_comb begin
    wait_max_d = stat_wait_max;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      wait_d[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !gnt_pick[i]) begin
        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : STAT_W'(wait_q[i] + 1'b1);
      end
      if (wait_d[i] > wait_max_d) begin
        wait_max_d = wait_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        wait_q[i] <= '0;
      end
      stat_grants   <= '0;
      stat_wait_max <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        wait_q[i] <= wait_d[i];
        if (gnt_pick[i] && (stat_grants[i*STAT_W +: STAT_W] != '1)) begin
          stat_grants[i*STAT_W +: STAT_W] <=
            STAT_W'(stat_grants[i*STAT_W +: STAT_W] + 1'b1);
        end
      end
      stat_wait_max <= wait_max_d;
    end
  end
`endif

endmodule
